// File: rtl/pwm_capture_pkg.sv
// rtl/pwm_capture_pkg.sv - shared state type and constants for the PWM capture block
package pwm_capture_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } pwm_cap_state_t;

    localparam int PWM_CAP_MIN_SYNC = 2;

endpackage

// File: rtl/pwm_sync.sv
// rtl/pwm_sync.sv - input synchronizer chain with rising-edge detect
module pwm_sync
    import pwm_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic synced,
    output logic rise
);

    // Depths below the minimum are raised to it rather than building an unsafe chain.
    localparam int STAGES = (SYNC_STAGES < PWM_CAP_MIN_SYNC) ? PWM_CAP_MIN_SYNC : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic              prev;

    // Everything resets high so an input already high at release is not seen as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev   <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pwm_in};
            prev   <= sync_q[STAGES-1];
        end
    end

    assign synced = sync_q[STAGES-1];
    assign rise   = synced & ~prev;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period/high-time capture; PWM_CAPTURE_TIMEOUT_EN adds constant-level timeout
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int size        = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pwm_in,
    output logic [size-1:0] cap_period,
    output logic [size-1:0] cap_compare,
    output logic            valid,
    output logic            timeout
);

    localparam logic [size-1:0] ALL_ONES = '1;

    logic           synced;
    logic           rise;
    logic [size-1:0] per_cnt;
    logic [size-1:0] hi_cnt;
    logic           capture;
    logic           timeout_hit;
    pwm_cap_state_t state;
    pwm_cap_state_t state_nxt;

    pwm_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .pwm_in(pwm_in),
        .synced(synced),
        .rise  (rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    capture = 1'b1;
`ifdef PWM_CAPTURE_TIMEOUT_EN
                end else if (per_cnt == ALL_ONES) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters reload on every rise; the rise cycle itself counts as the first high cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (rise) begin
            per_cnt <= '0;
            hi_cnt  <= size'(1);
        end else begin
            if (per_cnt != ALL_ONES) begin
                per_cnt <= per_cnt + 1'b1;
            end
            if (synced && (hi_cnt != ALL_ONES)) begin
                hi_cnt <= hi_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_period  <= '0;
            cap_compare <= '0;
            valid       <= 1'b0;
        end else begin
            valid <= capture | timeout_hit;
            if (capture) begin
                cap_period  <= per_cnt;
                cap_compare <= hi_cnt;
            end else if (timeout_hit) begin
                cap_period  <= ALL_ONES;
                cap_compare <= synced ? ALL_ONES : '0;
            end
        end
    end

`ifdef PWM_CAPTURE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout <= 1'b0;
        end else begin
            timeout <= timeout_hit;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture (24-bit and 8-bit instances)
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm = 1'b0;
    logic        pwm8 = 1'b0;
    logic [23:0] cap_p, cap_c;
    logic        valid, tmo;
    logic [7:0]  cap_p8, cap_c8;
    logic        valid8, tmo8;

    int n_assert = 0;
    int n_fail   = 0;

    // expectation state for the 24-bit instance
    int          step_no = 0;
    int          rises   = 0;
    logic        last_p  = 1'b0;
    logic        pend    = 1'b0;
    int          due     = 0;
    logic [23:0] pend_p, pend_c;
    logic [23:0] exp_p, exp_c;

    always #5 clk = ~clk;

    pwm_capture #(.size(24), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .pwm_in(pwm),
        .cap_period(cap_p), .cap_compare(cap_c), .valid(valid), .timeout(tmo)
    );

    pwm_capture #(.size(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst(rst), .pwm_in(pwm8),
        .cap_period(cap_p8), .cap_compare(cap_c8), .valid(valid8), .timeout(tmo8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drive one cycle of pwm; a rise driven at step s must produce valid at step s+2.
    task automatic drive(input logic p);
        logic exp_v;
        pwm = p;
        @(posedge clk);
        #1;
        step_no++;
        exp_v = pend && (due == step_no);
        if (exp_v) pend = 1'b0;
        chk("valid", {31'd0, valid}, {31'd0, exp_v});
        if (exp_v) begin
            chk("cap_period", {8'd0, cap_p}, {8'd0, pend_p});
            chk("cap_compare", {8'd0, cap_c}, {8'd0, pend_c});
        end
        if (p && !last_p) begin
            rises++;
            if (rises >= 2) begin
                pend   = 1'b1;
                due    = step_no + 2;
                pend_p = exp_p;
                pend_c = exp_c;
            end
        end
        last_p = p;
    endtask

    // One interval of h high / l low; ep/ec is what the rise opening it should capture.
    task automatic period(input int h, input int l, input logic [23:0] ep, input logic [23:0] ec);
        exp_p = ep;
        exp_c = ec;
        for (int i = 0; i < h + l; i++) drive(i < h);
    endtask

    task automatic reset_step(input logic p);
        pwm = p;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step_no++;
        pend   = 1'b0;
        rises  = 0;
        last_p = p;
        chk("rst_cap_period", {8'd0, cap_p}, 32'd0);
        chk("rst_cap_compare", {8'd0, cap_c}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_timeout", {31'd0, tmo}, 32'd0);
    endtask

    task automatic step8();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int early;
        exp_p = '0;
        exp_c = '0;
        pend_p = '0;
        pend_c = '0;

        reset_step(1'b0);
        reset_step(1'b0);
        chk("rst_valid8", {31'd0, valid8}, 32'd0);
        chk("rst_cap_period8", {24'd0, cap_p8}, 32'd0);
        for (int i = 0; i < 5; i++) drive(1'b0);

        // constant period 3/7
        period(3, 7, 24'd0, 24'd0);
        for (int i = 0; i < 4; i++) period(3, 7, 24'd9, 24'd3);

        // duty change 3/7 -> 7/3
        period(7, 3, 24'd9, 24'd3);
        period(7, 3, 24'd9, 24'd7);
        period(7, 3, 24'd9, 24'd7);

        // minimum period
        period(1, 1, 24'd9, 24'd7);
        for (int i = 0; i < 6; i++) period(1, 1, 24'd1, 24'd1);

        // reset while measuring with the input high
        exp_p = 24'd1;
        exp_c = 24'd1;
        drive(1'b1);
        drive(1'b1);
        reset_step(1'b1);
        for (int i = 0; i < 7; i++) drive(1'b0);
        period(3, 7, 24'd0, 24'd0);
        chk("hold_after_rst", {8'd0, cap_p}, 32'd0);
        period(3, 7, 24'd9, 24'd3);
        period(3, 7, 24'd9, 24'd3);
        drive(1'b0);
        drive(1'b0);

`ifdef PWM_CAPTURE_TIMEOUT_EN
        for (int r = 0; r < 2; r++) begin
            pwm8 = 1'b0;
            for (int i = 0; i < 3; i++) step8();
            early = 0;
            pwm8 = 1'b1;
            step8();
            pwm8 = (r == 0);
            for (int j = 1; j <= 257; j++) begin
                step8();
                if (valid8 || tmo8) early++;
            end
            chk("to_early", early, 32'd0);
            step8();
            chk("to_valid", {31'd0, valid8}, 32'd1);
            chk("to_timeout", {31'd0, tmo8}, 32'd1);
            chk("to_cap_period", {24'd0, cap_p8}, 32'd255);
            chk("to_cap_compare", {24'd0, cap_c8}, (r == 0) ? 32'd255 : 32'd0);
            step8();
            chk("to_valid_pulse", {31'd0, valid8}, 32'd0);
            chk("to_timeout_pulse", {31'd0, tmo8}, 32'd0);
            chk("to_hold", {24'd0, cap_p8}, 32'd255);
        end
`else
        pwm8 = 1'b0;
        for (int i = 0; i < 3; i++) step8();
        early = 0;
        pwm8 = 1'b1;
        step8();
        for (int j = 1; j <= 302; j++) begin
            pwm8 = (j == 300) ? 1'b0 : 1'b1;
            step8();
            if (valid8 || tmo8) early++;
        end
        chk("sat_no_valid", early, 32'd0);
        step8();
        chk("sat_valid", {31'd0, valid8}, 32'd1);
        chk("sat_timeout", {31'd0, tmo8}, 32'd0);
        chk("sat_cap_period", {24'd0, cap_p8}, 32'd255);
        chk("sat_cap_compare", {24'd0, cap_c8}, 32'd255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
